pipe_hazard_ctrl: RTL and testbench

- Hazard and sequencing controller for the five-stage RISC-V pipeline (IF/ID/EX/MEM/WB).
- Decodes the ID-stage instruction's opcode and register fields.
- Keeps a two-slot scoreboard of in-flight writers (EX, MEM) and drives the write-enable and flush controls of PC, IF/ID, ID/EX and back-end pipeline registers.
- Resolves load-use hazards, branch/jump redirects, and imem/dmem wait states; keeps stall/flush performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard and sequencing controller for a five-stage RISC-V pipeline
// (IF/ID/EX/MEM/WB). Decodes the ID-stage instruction, tracks the two
// in-flight writers sitting in EX and MEM, and drives the write-enable and
// flush controls of the PC, IF/ID, ID/EX and back-end pipeline registers.
// Also keeps saturating stall and redirect counters.
//
// Optional feature macro: PIPE_CTRL_FWD_EN
//   defined   : EX/MEM forwarding exists, only load-use in EX interlocks.
//   undefined : full interlock on any valid writer in EX or MEM.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   id_valid                      ID stage holds a real instruction
//   id_opcode/id_rs1/id_rs2/id_rd ID instruction fields
//   ex_redirect                   EX resolved a taken branch or jump
//   imem_ready, dmem_ready        memory wait-state handshakes
//   pc_we, ifid_we, back_we       pipeline register load enables
//   ifid_flush, idex_flush        bubble insertion controls
//   stall_cnt, flush_cnt          saturating performance counters
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             ex_redirect,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             back_we,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [6:0] {
    OP_R     = 7'b0110011,
    OP_I     = 7'b0010011,
    OP_LOAD  = 7'b0000011,
    OP_STORE = 7'b0100011,
    OP_B     = 7'b1100011,
    OP_LUI   = 7'b0110111,
    OP_AUIPC = 7'b0010111,
    OP_JAL   = 7'b1101111,
    OP_JALR  = 7'b1100111
  } opcode_e;

  // Non-writers are recorded with rd=0 so they can never match a source.
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       load;
    logic       mem;
  } slot_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  slot_t            ex_slot_q, ex_slot_d, mem_slot_q, mem_slot_d, id_slot;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             use_rs1, use_rs2, wr_rd, is_load, is_mem;
  logic             src1_live, src2_live, ex_hit, freeze, hazard, issue;

  // Decode the ID opcode into source usage, destination and memory class.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    wr_rd   = 1'b0;
    is_load = 1'b0;
    is_mem  = 1'b0;
    case (id_opcode)
      OP_R:     begin use_rs1 = 1'b1; use_rs2 = 1'b1; wr_rd = 1'b1; end
      OP_I:     begin use_rs1 = 1'b1; wr_rd = 1'b1; end
      OP_LOAD:  begin use_rs1 = 1'b1; wr_rd = 1'b1; is_load = 1'b1; is_mem = 1'b1; end
      OP_STORE: begin use_rs1 = 1'b1; use_rs2 = 1'b1; is_mem = 1'b1; end
      OP_B:     begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_LUI, OP_AUIPC, OP_JAL: wr_rd = 1'b1;
      OP_JALR:  begin use_rs1 = 1'b1; wr_rd = 1'b1; end
      default:  ;
    endcase
    id_slot.v    = 1'b1;
    id_slot.rd   = (wr_rd && id_rd != 5'd0) ? id_rd : 5'd0;
    id_slot.load = is_load;
    id_slot.mem  = is_mem;
  end

  // x0 is never a real dependency, so it is masked out of the source set.
  assign src1_live = use_rs1 && (id_rs1 != 5'd0);
  assign src2_live = use_rs2 && (id_rs2 != 5'd0);

  assign ex_hit = ex_slot_q.v && (ex_slot_q.rd != 5'd0) &&
                  ((src1_live && id_rs1 == ex_slot_q.rd) ||
                   (src2_live && id_rs2 == ex_slot_q.rd));

`ifdef PIPE_CTRL_FWD_EN
  // Forwarding covers everything except a load result still in EX.
  assign hazard = id_valid && ex_hit && ex_slot_q.load;

  logic unused_slot_bits;
  assign unused_slot_bits = ^{mem_slot_q.rd, mem_slot_q.load};
`else
  // Full interlock: WB is write-first, so only EX and MEM writers matter.
  logic mem_hit;
  assign mem_hit = mem_slot_q.v && (mem_slot_q.rd != 5'd0) &&
                   ((src1_live && id_rs1 == mem_slot_q.rd) ||
                    (src2_live && id_rs2 == mem_slot_q.rd));
  assign hazard = id_valid && (ex_hit || mem_hit);

  logic unused_slot_bits;
  assign unused_slot_bits = mem_slot_q.load;
`endif

  assign freeze = mem_slot_q.v && mem_slot_q.mem && !dmem_ready;
  assign issue  = id_valid && !hazard && !ex_redirect;

  // Control outputs, resolved in strict priority order.
  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    back_we    = 1'b1;
    if (rst) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      back_we    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (freeze) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      back_we = 1'b0;
    end else if (ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (hazard) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end else if (!imem_ready) begin
      pc_we      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  // Scoreboard advance and counter next-state; a freeze holds both slots.
  always_comb begin
    ex_slot_d   = ex_slot_q;
    mem_slot_d  = mem_slot_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!freeze) begin
      mem_slot_d = ex_slot_q;
      ex_slot_d  = issue ? id_slot : '0;
      if (ex_redirect && flush_cnt_q != CNT_MAX)
        flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
    if (!pc_we && stall_cnt_q != CNT_MAX)
      stall_cnt_d = stall_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_slot_q   <= '0;
      mem_slot_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_slot_q   <= ex_slot_d;
      mem_slot_q  <= mem_slot_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl. A behavioural model of the in-flight
// writers is checked against the DUT every cycle, and literal expectations
// pin the key scenarios. Counters are narrowed to 4 bits to reach saturation.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

`ifdef PIPE_CTRL_FWD_EN
  localparam int FWD         = 1;
  localparam int ADD_STALLS  = 1;
  localparam int ADDI_STALLS = 0;
`else
  localparam int FWD         = 0;
  localparam int ADD_STALLS  = 2;
  localparam int ADDI_STALLS = 2;
`endif

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011,
                         ST = 7'b0100011, LUI = 7'b0110111;

  logic clk = 1'b0;
  logic rst, id_valid, ex_redirect, imem_ready, dmem_ready;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic pc_we, ifid_we, ifid_flush, idex_flush, back_we;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int  n_vec = 0;
  int  n_miss = 0;
  bit  chk_en = 1'b0;
  int  exp_stall = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_redirect(ex_redirect), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .back_we(back_we),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic checkOutput(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  // Model: the instructions in flight, described by what they write.
  typedef struct {bit v; int rd; bit load; bit mem;} ent_t;
  typedef struct {bit use1; bit use2; bit writes; bit load; bit mem;} info_t;

  ent_t m_ex, m_mem;
  int   m_stall = 0;
  int   m_flush = 0;

  function automatic info_t classify(input logic [6:0] op);
    info_t c = '{0, 0, 0, 0, 0};
    if (op == R)                                   begin c.use1 = 1; c.use2 = 1; c.writes = 1; end
    else if (op == I || op == 7'b1100111)          begin c.use1 = 1; c.writes = 1; end
    else if (op == LD)                             begin c.use1 = 1; c.writes = 1; c.load = 1; c.mem = 1; end
    else if (op == ST)                             begin c.use1 = 1; c.use2 = 1; c.mem = 1; end
    else if (op == 7'b1100011)                     begin c.use1 = 1; c.use2 = 1; end
    else if (op == LUI || op == 7'b0010111 || op == 7'b1101111) c.writes = 1;
    return c;
  endfunction

  function automatic bit reads(input ent_t e, input info_t c, input int s1, input int s2);
    if (!e.v || e.rd == 0) return 0;
    return (c.use1 && s1 == e.rd) || (c.use2 && s2 == e.rd);
  endfunction

  // Compare process: expected outputs from the model, then advance the model.
  always @(negedge clk) begin
    if (chk_en) begin
      info_t c;
      bit frz, haz;
      int e_pc, e_ifwe, e_iff, e_idf, e_back;
      c   = classify(id_opcode);
      frz = m_mem.v && m_mem.mem && !dmem_ready;
      if (FWD == 1) haz = id_valid && m_ex.load && reads(m_ex, c, id_rs1, id_rs2);
      else          haz = id_valid && (reads(m_ex, c, id_rs1, id_rs2) || reads(m_mem, c, id_rs1, id_rs2));
      {e_pc, e_ifwe, e_iff, e_idf, e_back} = {32'd1, 32'd1, 32'd0, 32'd0, 32'd1};
      if (rst)              {e_pc, e_ifwe, e_iff, e_idf, e_back} = {32'd0, 32'd0, 32'd1, 32'd1, 32'd0};
      else if (frz)         {e_pc, e_ifwe, e_back} = {32'd0, 32'd0, 32'd0};
      else if (ex_redirect) {e_iff, e_idf} = {32'd1, 32'd1};
      else if (haz)         {e_pc, e_ifwe, e_idf} = {32'd0, 32'd0, 32'd1};
      else if (!imem_ready) {e_pc, e_iff} = {32'd0, 32'd1};
      checkOutput("model pc_we", pc_we, e_pc);
      checkOutput("model ifid_we", ifid_we, e_ifwe);
      checkOutput("model ifid_flush", ifid_flush, e_iff);
      checkOutput("model idex_flush", idex_flush, e_idf);
      checkOutput("model back_we", back_we, e_back);
      checkOutput("model stall_cnt", stall_cnt, m_stall);
      checkOutput("model flush_cnt", flush_cnt, m_flush);
      if (rst) begin
        m_ex = '{0, 0, 0, 0}; m_mem = '{0, 0, 0, 0}; m_stall = 0; m_flush = 0;
      end else begin
        if (e_pc == 0) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
        if (!frz) begin
          if (ex_redirect) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
          m_mem = m_ex;
          if (id_valid && !haz && !ex_redirect)
            m_ex = '{1, (c.writes ? int'(id_rd) : 0), c.load, c.mem};
          else
            m_ex = '{0, 0, 0, 0};
        end
      end
    end
  end

  // One pipeline cycle: drive inputs after the edge, return after the sample.
  task automatic applyStimulus(input bit r, input bit v, input logic [6:0] op,
                               input int s1, input int s2, input int d,
                               input bit red, input bit im, input bit dm);
    @(posedge clk); #1;
    rst = r; id_valid = v; id_opcode = op;
    id_rs1 = 5'(s1); id_rs2 = 5'(s2); id_rd = 5'(d);
    ex_redirect = red; imem_ready = im; dmem_ready = dm;
    @(negedge clk); #1;
  endtask

  task automatic idle(input bit im, input bit dm);
    applyStimulus(0, 0, 7'd0, 0, 0, 0, 0, im, dm);
  endtask

  initial begin
    m_ex = '{0, 0, 0, 0};
    m_mem = '{0, 0, 0, 0};
    rst = 1; id_valid = 0; id_opcode = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    ex_redirect = 0; imem_ready = 1; dmem_ready = 1;
    @(posedge clk); #1;
    chk_en = 1;

    // Reset state.
    applyStimulus(1, 0, 7'd0, 0, 0, 0, 0, 1, 1);
    checkOutput("rst pc_we", pc_we, 0);
    checkOutput("rst back_we", back_we, 0);
    checkOutput("rst ifid_flush", ifid_flush, 1);
    checkOutput("rst idex_flush", idex_flush, 1);

    // lw x5 ; add x6,x5,x1 ; addi x7,x6,1
    applyStimulus(0, 1, LD, 1, 0, 5, 0, 1, 1);
    checkOutput("load issue pc_we", pc_we, 1);
    checkOutput("cnt after reset", stall_cnt, 0);
    for (int i = 0; i <= ADD_STALLS; i++) begin
      applyStimulus(0, 1, R, 5, 1, 6, 0, 1, 1);
      if (i == 0) begin
        checkOutput("load-use pc_we", pc_we, 0);
        checkOutput("load-use idex_flush", idex_flush, 1);
      end
      if (i == ADD_STALLS) checkOutput("add issues pc_we", pc_we, 1);
    end
    exp_stall = ADD_STALLS;
    for (int i = 0; i <= ADDI_STALLS; i++) begin
      applyStimulus(0, 1, I, 6, 0, 7, 0, 1, 1);
      if (i == 0) checkOutput("stall_cnt after add", stall_cnt, exp_stall);
      if (i == ADDI_STALLS) checkOutput("addi issues pc_we", pc_we, 1);
    end
    exp_stall += ADDI_STALLS;
    idle(1, 1);
    checkOutput("stall_cnt after addi", stall_cnt, exp_stall);

    // Redirect overrides a load-use hazard; the add never reaches EX.
    applyStimulus(0, 1, LD, 1, 0, 5, 0, 1, 1);
    applyStimulus(0, 1, R, 5, 1, 6, 1, 0, 1);
    checkOutput("redirect pc_we", pc_we, 1);
    checkOutput("redirect ifid_flush", ifid_flush, 1);
    checkOutput("redirect idex_flush", idex_flush, 1);
    checkOutput("redirect back_we", back_we, 1);
    applyStimulus(0, 1, I, 6, 0, 7, 0, 1, 1);
    checkOutput("flush_cnt after redirect", flush_cnt, 1);
    checkOutput("post-redirect no hazard", pc_we, 1);

    // sw in MEM with three dmem wait cycles.
    applyStimulus(0, 1, ST, 2, 3, 9, 0, 1, 1);
    idle(1, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, LUI, 0, 0, 8, 0, 1, 0);
      checkOutput("freeze pc_we", pc_we, 0);
      checkOutput("freeze back_we", back_we, 0);
      checkOutput("freeze idex_flush", idex_flush, 0);
    end
    exp_stall += 3;
    applyStimulus(0, 1, LUI, 0, 0, 8, 0, 1, 1);
    checkOutput("freeze release pc_we", pc_we, 1);
    checkOutput("stall_cnt after freeze", stall_cnt, exp_stall);

    // imem wait with LUI then a load to x0; x0 readers never interlock.
    applyStimulus(0, 1, LUI, 0, 0, 10, 0, 0, 1);
    checkOutput("imem wait pc_we", pc_we, 0);
    checkOutput("imem wait ifid_flush", ifid_flush, 1);
    checkOutput("imem wait idex_flush", idex_flush, 0);
    applyStimulus(0, 1, LD, 1, 0, 0, 0, 0, 1);
    exp_stall += 2;
    applyStimulus(0, 1, R, 0, 0, 9, 0, 1, 1);
    checkOutput("x0 no hazard pc_we", pc_we, 1);
    checkOutput("stall_cnt after imem", stall_cnt, exp_stall);

    // Saturation of both counters.
    for (int i = 0; i < 20; i++) idle(0, 1);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 7'd0, 0, 0, 0, 1, 1, 1);
    idle(1, 1);
    checkOutput("stall_cnt saturated", stall_cnt, CMAX);
    checkOutput("flush_cnt saturated", flush_cnt, CMAX);

    // Reset in the middle of a freeze.
    applyStimulus(0, 1, ST, 2, 3, 0, 0, 1, 1);
    idle(1, 1);
    idle(1, 0);
    checkOutput("pre-reset freeze back_we", back_we, 0);
    applyStimulus(1, 0, 7'd0, 0, 0, 0, 0, 1, 0);
    checkOutput("rst in freeze pc_we", pc_we, 0);
    checkOutput("rst in freeze ifid_flush", ifid_flush, 1);
    checkOutput("rst in freeze idex_flush", idex_flush, 1);
    idle(1, 0);
    checkOutput("post-reset pc_we", pc_we, 1);
    checkOutput("post-reset back_we", back_we, 1);
    checkOutput("post-reset stall_cnt", stall_cnt, 0);
    checkOutput("post-reset flush_cnt", flush_cnt, 0);
    idle(1, 1);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
